// File: rtl/debounce_pkg.sv
// Shared constants for the synchroniser/debouncer slice: FSM encodings (bit1 = debounced level)
// and default sizing.
package debounce_pkg;

   localparam logic [1:0] ST_STABLE_LO = 2'b00;
   localparam logic [1:0] ST_PEND_HI   = 2'b01;
   localparam logic [1:0] ST_STABLE_HI = 2'b11;
   localparam logic [1:0] ST_PEND_LO   = 2'b10;

   localparam int unsigned DEF_SYNC_STAGES     = 2;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;

   function automatic logic [1:0] stable_st(input logic lvl);
      return lvl ? ST_STABLE_HI : ST_STABLE_LO;
   endfunction

   function automatic logic [1:0] pend_st(input logic lvl);
      return lvl ? ST_PEND_HI : ST_PEND_LO;
   endfunction

endpackage

// File: rtl/sync_chain.sv
// Generic N-flop synchroniser with asynchronous active-low reset to a configurable level.
module sync_chain #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ff_q <= {STAGES{RST_VAL}};
      end else begin
         ff_q <= {ff_q[STAGES-2:0], d};
      end
   end

   assign q = ff_q[STAGES-1];

endmodule

// File: rtl/sync_debouncer.sv
// Synchronises a raw bouncy input and accepts a new level only after DEBOUNCE_CYCLES stable samples.
// Optional rejected-transition counter enabled by defining SYNC_DEBOUNCE_GLITCH_CNT_EN.
module sync_debouncer
   import debounce_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter logic        RST_LEVEL       = 1'b0
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
   ,
   parameter int unsigned GLITCH_W        = 8
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                din,
   output logic                dout,
   output logic                busy
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
   ,
   output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             s;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q;
   logic             abort;

   sync_chain #(
      .STAGES (SYNC_STAGES),
      .RST_VAL(RST_LEVEL)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (din),
      .q  (s)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      abort   = 1'b0;
      unique case (state_q)
         ST_STABLE_LO, ST_STABLE_HI: begin
            cnt_d = '0;
            if (s != state_q[1]) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d = stable_st(s);
               end else begin
                  state_d = pend_st(s);
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         ST_PEND_HI, ST_PEND_LO: begin
            // Candidate level is the complement of the current (still held) output level.
            if (s != state_q[1]) begin
               if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                  state_d = stable_st(s);
                  cnt_d   = '0;
               end else begin
                  cnt_d = CNT_W'(cnt_q + 1'b1);
               end
            end else begin
               state_d = stable_st(state_q[1]);
               cnt_d   = '0;
               abort   = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= stable_st(RST_LEVEL);
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= state_d[1] ^ state_d[0];
      end
   end

   assign dout = state_q[1];
   assign busy = busy_q;

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
   logic [GLITCH_W-1:0] glitch_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         glitch_q <= '0;
      end else if (abort && (glitch_q != {GLITCH_W{1'b1}})) begin
         glitch_q <= glitch_q + 1'b1;
      end
   end

   assign glitch_cnt = glitch_q;
`else
   logic unused_abort;
   assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_sync_debouncer.sv
// Bench for sync_debouncer: default instance plus a SYNC_STAGES=3 / DEBOUNCE_CYCLES=1 instance,
// both checked every cycle against a run-length reference model.
module tb_sync_debouncer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic din;
   logic dout0, busy0, dout1, busy1;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
   logic [7:0] glitch0;
   logic [7:0] glitch1;
`endif

   sync_debouncer u_dut0 (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .dout      (dout0),
      .busy      (busy0)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
      ,
      .glitch_cnt(glitch0)
`endif
   );

   sync_debouncer #(
      .SYNC_STAGES    (3),
      .DEBOUNCE_CYCLES(1)
   ) u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .dout      (dout1),
      .busy      (busy1)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
      ,
      .glitch_cnt(glitch1)
`endif
   );

   int tests = 0;
   int fails = 0;
   int edge_n = 0;
   int cap = 0;
   int rise0 = -1;
   int rise1 = -1;
   logic prev0, prev1;

   // Reference model: the synchronised sample is din from SYNC edges ago; the output flips once
   // the sample has disagreed with it for DC consecutive edges.
   int   syn[2] = '{2, 3};
   int   dcs[2] = '{16, 1};
   logic hist[2][4];
   logic mdout[2];
   logic mbusy[2];
   int   run[2];
   int   mglit[2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 4; i++) hist[m][i] = 1'b0;
         mdout[m] = 1'b0;
         mbusy[m] = 1'b0;
         run[m]   = 0;
         mglit[m] = 0;
      end
   endtask

   task automatic model_edge(input int m, input logic v);
      logic smp;
      smp = hist[m][syn[m]-1];
      for (int i = 3; i > 0; i--) hist[m][i] = hist[m][i-1];
      hist[m][0] = v;
      if (smp != mdout[m]) begin
         run[m]++;
         if (run[m] == dcs[m]) begin
            mdout[m] = smp;
            run[m]   = 0;
            mbusy[m] = 1'b0;
         end else begin
            mbusy[m] = 1'b1;
         end
      end else begin
         if (run[m] > 0 && mglit[m] < 255) mglit[m]++;
         run[m]   = 0;
         mbusy[m] = 1'b0;
      end
   endtask

   task automatic step(input logic v);
      din = v;
      prev0 = dout0;
      prev1 = dout1;
      @(posedge clk);
      edge_n++;
      #1;
      model_edge(0, v);
      model_edge(1, v);
      if (!prev0 && dout0) rise0 = edge_n;
      if (!prev1 && dout1) rise1 = edge_n;
      check("dout_def", dout0, mdout[0]);
      check("busy_def", busy0, mbusy[0]);
      check("dout_dc1", dout1, mdout[1]);
      check("busy_dc1", busy1, mbusy[1]);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
      check("glitch_def", glitch0, mglit[0]);
      check("glitch_dc1", glitch1, mglit[1]);
`endif
   endtask

   initial begin
      rst = 1'b0;
      din = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_dout_def", dout0, 1'b0);
      check("rst_busy_def", busy0, 1'b0);
      check("rst_dout_dc1", dout1, 1'b0);
      check("rst_busy_dc1", busy1, 1'b0);
      rst = 1'b1;

      repeat (40) step(1'b0);

      // Single clean rising transition: fixed latency for both configurations.
      cap = edge_n + 1;
      rise0 = -1;
      rise1 = -1;
      repeat (22) step(1'b1);
      check("lat_def", rise0 - cap, 17);
      check("lat_dc1", rise1 - cap, 3);
      repeat (22) step(1'b0);

      // Short pulse is rejected.
      repeat (5) step(1'b1);
      repeat (25) step(1'b0);
      check("pulse_dout", dout0, 1'b0);

      // Bounce burst followed by a stable high level.
      for (int b = 0; b < 6; b++) begin
         repeat ($urandom_range(1, 3)) step(1'b1);
         repeat ($urandom_range(1, 3)) step(1'b0);
      end
      cap = edge_n + 1;
      rise0 = -1;
      repeat (24) step(1'b1);
      check("lat_bounce", rise0 - cap, 17);
      repeat (22) step(1'b0);

      // Asynchronous reset in the middle of qualifying a rising edge.
      repeat (10) step(1'b1);
      check("busy_before_rst", busy0, 1'b1);
      rst = 1'b0;
      #1;
      model_reset();
      check("midrst_dout_def", dout0, 1'b0);
      check("midrst_busy_def", busy0, 1'b0);
      check("midrst_dout_dc1", dout1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      cap = edge_n + 1;
      rise0 = -1;
      repeat (22) step(1'b1);
      check("lat_after_rst", rise0 - cap, 17);

      // Random hold lengths straddling the debounce window.
      for (int r = 0; r < 60; r++) begin
         logic v;
         v = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 24)) step(v);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
